// File: rtl/write_rr_arbiter_if.sv
// Write-arbiter bus: per-port requests/end-of-burst marks in, one-hot grant and beat strobe out.
interface write_rr_arbiter_if #(
    parameter int num_of_ports = 16,
    parameter int id_width     = 4
);
  logic [num_of_ports-1:0] req;
  logic [num_of_ports-1:0] req_last;
  logic                    sram_ready;
  logic [num_of_ports-1:0] grant;
  logic                    grant_valid;
  logic [id_width-1:0]     grant_id;
  logic                    beat_en;
  logic [6:0]              burst_cnt;
  logic                    timeout_err;

  modport master (
    output req, req_last, sram_ready,
    input  grant, grant_valid, grant_id, beat_en, burst_cnt, timeout_err
  );

  modport slave (
    input  req, req_last, sram_ready,
    output grant, grant_valid, grant_id, beat_en, burst_cnt, timeout_err
  );
endinterface

// File: rtl/write_rr_arbiter.sv
// Round-robin burst write arbiter: 1-clk req->grant, grant held to last beat or max_burst; beats gated by sram_ready.
// Optional WRITE_ARB_WATCHDOG_EN releases a grant whose port stays idle for wd_timeout cycles.
module write_rr_arbiter #(
    parameter int num_of_ports = 16,
    parameter int max_burst    = 64,
    parameter int id_width     = 4
`ifdef WRITE_ARB_WATCHDOG_EN
    ,
    parameter int wd_timeout   = 255
`endif
) (
    input logic                clk,
    input logic                rst_n,
    write_rr_arbiter_if.slave  arb
);
  typedef enum logic {IDLE, BURST} state_t;

  state_t                  r_state, w_state_nxt;
  logic [num_of_ports-1:0] r_grant, w_grant_nxt;
  logic [id_width-1:0]     r_grant_id, w_grant_id_nxt;
  logic [6:0]              r_burst_cnt, w_burst_cnt_nxt;
  logic [id_width-1:0]     r_ptr, w_ptr_nxt;

  logic                    w_found;
  logic [id_width-1:0]     w_pick;
  logic                    w_beat;
  logic                    w_cnt_max;
  logic                    w_wd_fire;
  logic                    w_release;

  // Scan downward in offset so the lowest offset from the pointer wins; id wraps naturally.
  always_comb begin
    logic [id_width-1:0] idx;
    w_found = 1'b0;
    w_pick  = r_ptr;
    idx     = r_ptr;
    for (int i = num_of_ports - 1; i >= 0; i--) begin
      idx = r_ptr + id_width'(i);
      if (arb.req[idx]) begin
        w_found = 1'b1;
        w_pick  = idx;
      end
    end
  end

  assign w_beat    = (r_state == BURST) & arb.req[r_grant_id] & arb.sram_ready;
  assign w_cnt_max = (r_burst_cnt == 7'(max_burst - 1));
  assign w_release = (w_beat & (arb.req_last[r_grant_id] | w_cnt_max)) | w_wd_fire;

`ifdef WRITE_ARB_WATCHDOG_EN
  localparam int WD_W = $clog2(wd_timeout + 1);
  logic [WD_W-1:0] r_idle_cnt;

  assign w_wd_fire = (r_state == BURST) & ~arb.req[r_grant_id]
                     & (r_idle_cnt == WD_W'(wd_timeout - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idle_cnt <= '0;
    end else if ((r_state != BURST) || arb.req[r_grant_id] || w_release) begin
      r_idle_cnt <= '0;
    end else begin
      r_idle_cnt <= r_idle_cnt + WD_W'(1);
    end
  end

  assign arb.timeout_err = w_wd_fire;
`else
  assign w_wd_fire       = 1'b0;
  assign arb.timeout_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_grant     <= '0;
      r_grant_id  <= '0;
      r_burst_cnt <= '0;
      r_ptr       <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_grant     <= w_grant_nxt;
      r_grant_id  <= w_grant_id_nxt;
      r_burst_cnt <= w_burst_cnt_nxt;
      r_ptr       <= w_ptr_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_grant_nxt     = r_grant;
    w_grant_id_nxt  = r_grant_id;
    w_burst_cnt_nxt = r_burst_cnt;
    w_ptr_nxt       = r_ptr;
    case (r_state)
      IDLE: begin
        if (w_found) begin
          w_state_nxt     = BURST;
          w_grant_nxt     = num_of_ports'(1) << w_pick;
          w_grant_id_nxt  = w_pick;
          w_burst_cnt_nxt = '0;
        end
      end
      BURST: begin
        // Pointer moves only on release, bounding every requester's wait.
        if (w_release) begin
          w_state_nxt     = IDLE;
          w_grant_nxt     = '0;
          w_grant_id_nxt  = '0;
          w_burst_cnt_nxt = '0;
          w_ptr_nxt       = r_grant_id + id_width'(1);
        end else if (w_beat) begin
          w_burst_cnt_nxt = r_burst_cnt + 7'd1;
        end
      end
    endcase
  end

  assign arb.grant       = r_grant;
  assign arb.grant_valid = (r_state == BURST);
  assign arb.grant_id    = r_grant_id;
  assign arb.beat_en     = w_beat;
  assign arb.burst_cnt   = r_burst_cnt;
endmodule

// File: tb/tb_write_rr_arbiter.sv
// Bench for write_rr_arbiter: vector table, directed corner sequences, then random traffic vs a reference model.
module tb_write_rr_arbiter;
  localparam int NP  = 16;
  localparam int MB  = 64;
  localparam int IDW = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  write_rr_arbiter_if #(.num_of_ports(NP), .id_width(IDW)) bus ();

  write_rr_arbiter #(.num_of_ports(NP), .max_burst(MB), .id_width(IDW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .arb   (bus)
  );

  typedef struct {
    logic [15:0] req;
    logic [15:0] last;
    logic        rdy;
    logic [15:0] g;
    logic        gv;
    logic [3:0]  gid;
    logic        beat;
    logic [6:0]  cnt;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic drive(input logic [15:0] r, input logic [15:0] l, input logic rd);
    bus.req        = r;
    bus.req_last   = l;
    bus.sram_ready = rd;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    drive(16'h0, 16'h0, 1'b0);
    smp();
    chk("rst_grant", 32'(bus.grant), 0);
    chk("rst_gv", 32'(bus.grant_valid), 0);
    chk("rst_gid", 32'(bus.grant_id), 0);
    chk("rst_beat", 32'(bus.beat_en), 0);
    chk("rst_cnt", 32'(bus.burst_cnt), 0);
    chk("rst_tmo", 32'(bus.timeout_err), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    vec_t tbl[12];
    int   beats, peak, prev_cnt;
    bit   done, seen, prev_gv, prev_rdy;
    logic rd;
    logic [15:0] r, l;
    int   m_gp, m_cnt, m_ptr, pick;
    logic [15:0] exp_g;
    logic exp_beat;

    tbl[0]  = '{16'h0001, 16'h0000, 1'b1, 16'h0000, 1'b0, 4'd0, 1'b0, 7'd0};
    tbl[1]  = '{16'h0001, 16'h0000, 1'b1, 16'h0001, 1'b1, 4'd0, 1'b1, 7'd0};
    tbl[2]  = '{16'h0001, 16'h0002, 1'b1, 16'h0001, 1'b1, 4'd0, 1'b1, 7'd1};
    tbl[3]  = '{16'h0001, 16'h0001, 1'b0, 16'h0001, 1'b1, 4'd0, 1'b0, 7'd2};
    tbl[4]  = '{16'h0000, 16'h0000, 1'b1, 16'h0001, 1'b1, 4'd0, 1'b0, 7'd2};
    tbl[5]  = '{16'h0006, 16'h0000, 1'b1, 16'h0001, 1'b1, 4'd0, 1'b0, 7'd2};
    tbl[6]  = '{16'h0001, 16'h0000, 1'b1, 16'h0001, 1'b1, 4'd0, 1'b1, 7'd2};
    tbl[7]  = '{16'h0001, 16'h0001, 1'b1, 16'h0001, 1'b1, 4'd0, 1'b1, 7'd3};
    tbl[8]  = '{16'h0000, 16'h0000, 1'b1, 16'h0000, 1'b0, 4'd0, 1'b0, 7'd0};
    tbl[9]  = '{16'h0003, 16'h0000, 1'b1, 16'h0000, 1'b0, 4'd0, 1'b0, 7'd0};
    tbl[10] = '{16'h0003, 16'h0002, 1'b1, 16'h0002, 1'b1, 4'd1, 1'b1, 7'd0};
    tbl[11] = '{16'h0000, 16'h0000, 1'b1, 16'h0000, 1'b0, 4'd0, 1'b0, 7'd0};

    #3;
    do_reset();

    // Basic burst, hold/ignore cases, pointer advance to 1.
    for (int i = 0; i < 12; i++) begin
      drive(tbl[i].req, tbl[i].last, tbl[i].rdy);
      smp();
      chk($sformatf("tbl%0d_grant", i), 32'(bus.grant), 32'(tbl[i].g));
      chk($sformatf("tbl%0d_gv", i), 32'(bus.grant_valid), 32'(tbl[i].gv));
      if (tbl[i].gv) chk($sformatf("tbl%0d_gid", i), 32'(bus.grant_id), 32'(tbl[i].gid));
      chk($sformatf("tbl%0d_beat", i), 32'(bus.beat_en), 32'(tbl[i].beat));
      chk($sformatf("tbl%0d_cnt", i), 32'(bus.burst_cnt), 32'(tbl[i].cnt));
      cyc();
    end

    // Wrap-around: pointer 2 -> port 5, then pointer 6 with req 0x11 -> 0 then 4.
    drive(16'h0020, 16'h0020, 1'b1);
    smp(); chk("t3_idle", 32'(bus.grant_valid), 0); cyc();
    smp(); chk("t3_gid5", 32'(bus.grant_id), 5); chk("t3_beat5", 32'(bus.beat_en), 1); cyc();
    drive(16'h0011, 16'h0011, 1'b1);
    smp(); chk("t3_gap", 32'(bus.grant_valid), 0); cyc();
    smp(); chk("t3_wrap_gid", 32'(bus.grant_id), 0); chk("t3_wrap_gv", 32'(bus.grant_valid), 1); cyc();
    smp(); chk("t3_gap2", 32'(bus.grant_valid), 0); cyc();
    smp(); chk("t3_gid4", 32'(bus.grant_id), 4); cyc();
    drive(16'h0000, 16'h0000, 1'b1);

    // Forced release at max_burst with no req_last.
    drive(16'h0100, 16'h0000, 1'b1);
    beats = 0; peak = 0; done = 0; seen = 0;
    for (int c = 0; c < 200 && !done; c++) begin
      smp();
      if (bus.grant_valid) seen = 1;
      if (bus.beat_en) beats++;
      if (int'(bus.burst_cnt) > peak) peak = int'(bus.burst_cnt);
      if (seen && !bus.grant_valid) begin
        done = 1;
        chk("t4_cnt_clear", 32'(bus.burst_cnt), 0);
        drive(16'h0000, 16'h0000, 1'b1);
      end
      cyc();
    end
    chk("t4_released", 32'(done), 1);
    chk("t4_beats", 32'(beats), MB);
    chk("t4_peak", 32'(peak), MB - 1);

    // Backpressure: ready toggles during a 3-beat burst on port 9; port 2 waits.
    beats = 0; done = 0; seen = 0; prev_gv = 0; prev_rdy = 1; prev_cnt = 0;
    for (int c = 0; c < 40 && !done; c++) begin
      rd = c[0];
      drive(16'h0204, (beats == 2) ? 16'h0200 : 16'h0000, rd);
      smp();
      if (bus.grant_valid) begin
        seen = 1;
        chk("t5_hold_gid", 32'(bus.grant_id), 9);
      end
      if (seen && !rd) chk("t5_no_beat", 32'(bus.beat_en), 0);
      if (bus.grant_valid && prev_gv && !prev_rdy) chk("t5_cnt_frozen", 32'(bus.burst_cnt), 32'(prev_cnt));
      if (bus.beat_en) beats++;
      if (seen && !bus.grant_valid) done = 1;
      prev_gv = bus.grant_valid; prev_rdy = rd; prev_cnt = int'(bus.burst_cnt);
      cyc();
    end
    chk("t5_released", 32'(done), 1);
    chk("t5_beats", 32'(beats), 3);
    drive(16'h0204, 16'h0004, 1'b1);
    smp(); chk("t5_waiter_gid", 32'(bus.grant_id), 2); chk("t5_waiter_beat", 32'(bus.beat_en), 1); cyc();
    drive(16'h0000, 16'h0000, 1'b1);

    // Async reset mid-burst on port 4; pointer returns to 0.
    drive(16'h0010, 16'h0000, 1'b1);
    smp(); cyc();
    smp(); chk("t6_gid4", 32'(bus.grant_id), 4); cyc();
    smp(); cyc();
    smp(); chk("t6_cnt2", 32'(bus.burst_cnt), 2);
    #1 rst_n = 1'b0;
    #1;
    chk("t6_async_grant", 32'(bus.grant), 0);
    chk("t6_async_gv", 32'(bus.grant_valid), 0);
    chk("t6_async_beat", 32'(bus.beat_en), 0);
    chk("t6_async_cnt", 32'(bus.burst_cnt), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    drive(16'hFFFF, 16'hFFFF, 1'b1);
    smp(); chk("t6_idle", 32'(bus.grant_valid), 0); cyc();
    smp(); chk("t6_ptr0_gid", 32'(bus.grant_id), 0); cyc();
    drive(16'h0000, 16'h0000, 1'b1);

    // All ports requesting, 1-beat bursts: 0..15,0 with a bubble between grants.
    do_reset();
    drive(16'hFFFF, 16'hFFFF, 1'b1);
    for (int k = 0; k <= NP; k++) begin
      smp(); chk("t2_gap", 32'(bus.grant_valid), 0); cyc();
      smp(); chk("t2_gid", 32'(bus.grant_id), 32'(k % NP)); chk("t2_onehot", 32'(bus.grant), 32'(1) << (k % NP)); cyc();
    end
    drive(16'h0000, 16'h0000, 1'b1);

    // Random traffic against the reference model.
    do_reset();
    m_gp = -1; m_cnt = 0; m_ptr = 0;
    for (int c = 0; c < 3000; c++) begin
      r  = 16'($urandom) & 16'($urandom);
      if ($urandom_range(0, 7) == 0) r = 16'h0;
      l  = 16'($urandom) & 16'($urandom) & 16'($urandom);
      rd = ($urandom_range(0, 3) != 0);
      drive(r, l, rd);
      smp();
      exp_g    = (m_gp >= 0) ? (16'h1 << m_gp) : 16'h0;
      exp_beat = (m_gp >= 0) && r[m_gp] && rd;
      chk("rnd_grant", 32'(bus.grant), 32'(exp_g));
      chk("rnd_gv", 32'(bus.grant_valid), 32'(m_gp >= 0));
      if (m_gp >= 0) chk("rnd_gid", 32'(bus.grant_id), 32'(m_gp));
      chk("rnd_beat", 32'(bus.beat_en), 32'(exp_beat));
      chk("rnd_cnt", 32'(bus.burst_cnt), 32'(m_cnt));
      chk("rnd_tmo", 32'(bus.timeout_err), 0);
      if (m_gp < 0) begin
        pick = -1;
        for (int k = NP - 1; k >= 0; k--)
          if (r[(m_ptr + k) % NP]) pick = (m_ptr + k) % NP;
        if (pick >= 0) begin
          m_gp  = pick;
          m_cnt = 0;
        end
      end else if (exp_beat) begin
        if (l[m_gp] || (m_cnt + 1 == MB)) begin
          m_ptr = (m_gp + 1) % NP;
          m_gp  = -1;
          m_cnt = 0;
        end else begin
          m_cnt++;
        end
      end
      cyc();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
